// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan driver.
// Segment bytes are ordered a..g, dp from bit 7 down to bit 0, active-high.
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned CODE_W     = 4;
  localparam int unsigned SEG_W      = 8;

  localparam int unsigned SEG_A  = 7;
  localparam int unsigned SEG_B  = 6;
  localparam int unsigned SEG_C  = 5;
  localparam int unsigned SEG_D  = 4;
  localparam int unsigned SEG_E  = 3;
  localparam int unsigned SEG_F  = 2;
  localparam int unsigned SEG_G  = 1;
  localparam int unsigned SEG_DP = 0;

  localparam logic [SEG_W-1:0] GLYPH_0    = 8'hFC;
  localparam logic [SEG_W-1:0] GLYPH_1    = 8'h60;
  localparam logic [SEG_W-1:0] GLYPH_2    = 8'hDA;
  localparam logic [SEG_W-1:0] GLYPH_3    = 8'hF2;
  localparam logic [SEG_W-1:0] GLYPH_4    = 8'h66;
  localparam logic [SEG_W-1:0] GLYPH_5    = 8'hB6;
  localparam logic [SEG_W-1:0] GLYPH_6    = 8'hBE;
  localparam logic [SEG_W-1:0] GLYPH_7    = 8'hE0;
  localparam logic [SEG_W-1:0] GLYPH_8    = 8'hFE;
  localparam logic [SEG_W-1:0] GLYPH_9    = 8'hE6;
  localparam logic [SEG_W-1:0] GLYPH_DASH = 8'h02;
  localparam logic [SEG_W-1:0] SEG_BLANK  = 8'h00;

  // One frame's worth of digit data, as captured at a frame boundary.
  typedef struct packed {
    logic [NUM_DIGITS*CODE_W-1:0] codes;
    logic [NUM_DIGITS-1:0]        on;
    logic [NUM_DIGITS-1:0]        dp;
    logic [NUM_DIGITS-1:0]        blink;
  } digit_frame_t;

  // Replace the glyph's dp position with the digit's own decimal point.
  function automatic logic [SEG_W-1:0] with_dp(input logic [SEG_W-1:0] glyph, input logic dp);
    return {glyph[SEG_A:SEG_G], dp};
  endfunction

endpackage

// File: rtl/seg_glyph_rom.sv
// Combinational digit-code to segment-glyph lookup; codes 10-15 show a dash.
module seg_glyph_rom
  import seg_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [SEG_W-1:0]  glyph_c
);

  always_comb begin
    glyph_c = GLYPH_DASH;
    case (code)
      4'd0:    glyph_c = GLYPH_0;
      4'd1:    glyph_c = GLYPH_1;
      4'd2:    glyph_c = GLYPH_2;
      4'd3:    glyph_c = GLYPH_3;
      4'd4:    glyph_c = GLYPH_4;
      4'd5:    glyph_c = GLYPH_5;
      4'd6:    glyph_c = GLYPH_6;
      4'd7:    glyph_c = GLYPH_7;
      4'd8:    glyph_c = GLYPH_8;
      4'd9:    glyph_c = GLYPH_9;
      default: glyph_c = GLYPH_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Scans eight digits onto two 4-digit seven-segment groups with shared digit
// enables; input data is latched once per frame and blinked per digit.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned SCAN_HZ      = 1000,
  parameter int unsigned BLINK_FRAMES = 125
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_DIGITS*CODE_W-1:0] digit_codes,
  input  logic [NUM_DIGITS-1:0]        digit_on,
  input  logic [NUM_DIGITS-1:0]        dp_on,
  input  logic [NUM_DIGITS-1:0]        blink_mask,
  output logic [NUM_DIGITS-1:0]        an,
  output logic [SEG_W-1:0]             seg_right,
  output logic [SEG_W-1:0]             seg_left,
  output logic                         frame_start
);

  localparam int unsigned DIV   = CLK_HZ / SCAN_HZ;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  if (DIV < 2) begin : g_bad_div
    $error("seg_scan_driver: CLK_HZ/SCAN_HZ must be at least 2");
  end
  if (BLINK_FRAMES < 1) begin : g_bad_blink
    $error("seg_scan_driver: BLINK_FRAMES must be at least 1");
  end

  logic [CNT_W-1:0] pre_cnt;
  logic [1:0]       idx;
  logic [FRM_W-1:0] frm_cnt;
  logic             blink_phase;
  digit_frame_t     shadow;

  logic tick_c;
  logic boundary_c;
  logic wrap_c;

  assign tick_c     = (pre_cnt == CNT_W'(DIV - 1));
  assign boundary_c = tick_c && (idx == 2'd3);
  assign wrap_c     = (frm_cnt == FRM_W'(BLINK_FRAMES - 1));

  // Prescaler and scan index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      idx     <= '0;
    end else if (tick_c) begin
      pre_cnt <= '0;
      idx     <= idx + 2'd1;
    end else begin
      pre_cnt <= pre_cnt + CNT_W'(1);
    end
  end

  // Frame boundary: reload shadows, advance blink timing, flag the new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow      <= '0;
      frm_cnt     <= '0;
      blink_phase <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= boundary_c;
      if (boundary_c) begin
        shadow <= '{codes: digit_codes, on: digit_on, dp: dp_on, blink: blink_mask};
        if (wrap_c) begin
          frm_cnt     <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frm_cnt <= frm_cnt + FRM_W'(1);
        end
      end
    end
  end

  logic [2:0]          dig_r_c;
  logic [2:0]          dig_l_c;
  logic [CODE_W-1:0]   code_r_c;
  logic [CODE_W-1:0]   code_l_c;
  logic [SEG_W-1:0]    glyph_r_c;
  logic [SEG_W-1:0]    glyph_l_c;
  logic                blank_r_c;
  logic                blank_l_c;
  logic [NUM_DIGITS-1:0] an_nxt_c;
  logic [SEG_W-1:0]    seg_r_nxt_c;
  logic [SEG_W-1:0]    seg_l_nxt_c;

  assign dig_r_c  = {1'b0, idx};
  assign dig_l_c  = {1'b1, idx};
  assign code_r_c = shadow.codes[{dig_r_c, 2'b00} +: CODE_W];
  assign code_l_c = shadow.codes[{dig_l_c, 2'b00} +: CODE_W];

  seg_glyph_rom u_rom_right (.code(code_r_c), .glyph_c(glyph_r_c));
  seg_glyph_rom u_rom_left  (.code(code_l_c), .glyph_c(glyph_l_c));

  // Blinking digits lose their dp as well as their segments.
  always_comb begin
    blank_r_c   = !shadow.on[dig_r_c] || (shadow.blink[dig_r_c] && blink_phase);
    blank_l_c   = !shadow.on[dig_l_c] || (shadow.blink[dig_l_c] && blink_phase);
    seg_r_nxt_c = blank_r_c ? SEG_BLANK : with_dp(glyph_r_c, shadow.dp[dig_r_c]);
    seg_l_nxt_c = blank_l_c ? SEG_BLANK : with_dp(glyph_l_c, shadow.dp[dig_l_c]);
    an_nxt_c          = '0;
    an_nxt_c[dig_r_c] = 1'b1;
    an_nxt_c[dig_l_c] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an        <= '0;
      seg_right <= '0;
      seg_left  <= '0;
    end else begin
      an        <= an_nxt_c;
      seg_right <= seg_r_nxt_c;
      seg_left  <= seg_l_nxt_c;
    end
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Display-side end of the digit-code interface: takes up to eight 4-bit digit codes plus per-digit blank, decimal-point and blink masks.
- Time-multiplexes them onto the board's two 4-digit seven-segment groups. Each group has its own 8-bit segment bus; all eight digits share one 8-bit digit-enable bus.
- Owns scan timing, frame-synchronous double buffering, blinking and code-to-segment decoding, so control FSMs only present static digit values.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency.
- SCAN_HZ, 1000, rate at which the scan index advances. DIV = CLK_HZ/SCAN_HZ; DIV ≥ 2 is required (elaboration error otherwise).
- BLINK_FRAMES, 125, number of complete frames per blink half-period; must be ≥ 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- digit_codes  input  32  digit i occupies bits [4i+3:4i]; i=0 is rightmost, i=7 leftmost.
- digit_on  input  8  1 = digit i lit, 0 = blanked.
- dp_on  input  8  1 = decimal point of digit i lit.
- blink_mask  input  8  1 = digit i blinks.
- an  output  8  digit enables, active-high; an[i] selects digit i.
- seg_right  output  8  segments for digits 0-3, bit7..0 = a,b,c,d,e,f,g,dp, active-high.
- seg_left  output  8  segments for digits 4-7, same encoding.
- frame_start  output  1  one-cycle pulse when a new frame's shadow data is loaded.

Behaviour:
- Reset (asynchronous, active-low): prescaler=0, scan index idx=0, frame counter=0, blink_phase=0, shadow registers=0; an=0, seg_right=0, seg_left=0, frame_start=0.
- Prescaler counts 0..DIV-1 and wraps. tick is asserted on the cycle where count==DIV-1.
- Scan index: 2-bit idx, range 0..3. On tick, idx ← idx+1, wrapping from 3 to 0. Each idx value is held for exactly DIV cycles.
- Frame boundary: tick with idx==3.
  - On that edge, digit_codes, digit_on, dp_on and blink_mask are copied into shadow registers.
  - frame_start is high for the following single cycle.
  - Inputs changing mid-frame never reach the outputs until the next boundary; no tearing.
- Blink:
  - Frame counter counts frame boundaries 0..BLINK_FRAMES-1.
  - On the boundary where it wraps, blink_phase toggles.
  - While blink_phase=1, every digit with shadow blink_mask=1 is blanked, including its dp.
- Outputs are registered and recomputed every cycle from idx and the shadow registers. They change one cycle after the clock edge on which idx changes.
  - an = (1<<idx) | (1<<(idx+4)), i.e. one digit lit per group.
  - seg_right = pattern(digit idx); seg_left = pattern(digit idx+4).
  - First frame after reset: shadows are 0, so all digits blank and an still scans.
- pattern(k):
  - If the digit is blanked (digit_on=0, or blinking and blink_phase=1): 8'h00.
  - Otherwise {glyph[7:1], dp_on[k]}, where glyph is the standard code table:
    - 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0, 8=FE, 9=E6.
    - Codes 10-15 display a dash, glyph 8'h02 (g only).
- Simultaneous events: a boundary that both reloads the shadows and toggles blink_phase applies both on the same edge. The new frame starts with the new shadows and new phase.
- Reset mid-scan: all state clears immediately and asynchronously; scanning restarts at idx=0 after release.

Decomposition:
- Shared package seg_pkg holds:
  - the 8-bit glyph constants for 0-9 and the dash;
  - the segment bit-order constants (SEG_A=7 … SEG_DP=0);
  - the blank value 8'h00.
- One sub-module, seg_glyph_rom: a combinational 4-bit code → 8-bit glyph lookup. It is instantiated twice, once per group. Timing, shadowing and blink logic stay in the top.

Test Plan:
- Bench parameters: CLK_HZ=8, SCAN_HZ=2 (DIV=4), BLINK_FRAMES=2.
- Reset behaviour: hold rst_n=0 → an=00, both seg buses 00, frame_start=0. Release → an cycles 11,22,44,88 with each value held 4 cycles; segs stay 00 until the first frame_start.
- Decoding: digit_codes=32'h7654_3210, digit_on=FF, dp_on=00. After the first frame_start: idx0 gives an=11, seg_right=FC, seg_left=66; idx3 gives an=88, seg_right=F2, seg_left=E0.
- Dash and dp: digit 0 code=C with dp_on[0]=1 → seg_right=03 when an[0]=1. digit_on[5]=0 → seg_left=00 when an[5]=1.
- Double buffering: change digit_codes[3:0] from 1 to 8 in mid-frame → seg_right at idx0 shows 60 until the next frame_start, then FE.
- Blink: blink_mask=01, BLINK_FRAMES=2 → digit 0 segments alternate lit/00 every 2 frames. Digits 1-7 are unaffected.
- Async reset mid-frame: assert rst_n=0 at idx=2 → outputs go 00 in the same cycle without waiting for a clock edge. After release, scanning resumes at idx=0, an=11 held 4 cycles.
